// File: rtl/regfile_read_ctrl.sv
// regfile_read_ctrl: 32-entry register file with two read ports, one write port and a pending-write stall scoreboard.
// Optional REG0_HARDWIRED_EN makes register 0 a constant zero that is never written, reserved or stalled on.
module regfile_read_ctrl #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rd_stall,
  input  logic              rsv_en,
  input  logic [4:0]        rsv_addr,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state;
  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0] pend, clr, set;
  logic [4:0] l_rs, l_rt, a_rs, a_rt;
  logic [DATA_W-1:0] v_rs, v_rt;
  logic wr_ok, rsv_ok, byp_rs, byp_rt, hz, go;
  always_comb begin
`ifdef REG0_HARDWIRED_EN
    wr_ok  = wr_en && wr_addr != 5'd0;
    rsv_ok = rsv_en && rsv_addr != 5'd0;
`else
    wr_ok  = wr_en;
    rsv_ok = rsv_en;
`endif
    a_rs   = state == S_WAIT ? l_rs : rs_addr;
    a_rt   = state == S_WAIT ? l_rt : rt_addr;
    byp_rs = wr_en && wr_addr == a_rs;
    byp_rt = wr_en && wr_addr == a_rt;
    // hazard looks at pending before this cycle's reserve lands
    hz     = (pend[a_rs] && !byp_rs) || (pend[a_rt] && !byp_rt);
    go     = state == S_WAIT || rd_req;
    v_rs   = byp_rs ? wr_data : regs[a_rs];
    v_rt   = byp_rt ? wr_data : regs[a_rt];
`ifdef REG0_HARDWIRED_EN
    v_rs   = a_rs == 5'd0 ? '0 : v_rs;
    v_rt   = a_rt == 5'd0 ? '0 : v_rt;
`endif
    clr    = {{(NREG-1){1'b0}}, wr_ok} << wr_addr;
    set    = {{(NREG-1){1'b0}}, rsv_ok} << rsv_addr;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs     <= '{default: '0};
      pend     <= '0;
      state    <= S_IDLE;
      l_rs     <= '0;
      l_rt     <= '0;
      rd_valid <= 1'b0;
      rd_stall <= 1'b0;
      rs_data  <= '0;
      rt_data  <= '0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      pend     <= (pend & ~clr) | set;
      rd_valid <= go && !hz;
      if (go && !hz) begin
        rs_data  <= v_rs;
        rt_data  <= v_rt;
        state    <= S_IDLE;
        rd_stall <= 1'b0;
      end else if (go) begin
        l_rs     <= a_rs;
        l_rt     <= a_rt;
        state    <= S_WAIT;
        rd_stall <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_read_ctrl.sv
// tb_regfile_read_ctrl: scoreboard bench; expected operand pairs are queued at request time and popped on rd_valid.
module tb_regfile_read_ctrl;
  logic clk = 0, rst_n = 0;
  logic rd_req = 0, rsv_en = 0, wr_en = 0;
  logic [4:0] rs_addr = 0, rt_addr = 0, rsv_addr = 0, wr_addr = 0;
  logic [31:0] wr_data = 0;
  logic rd_valid, rd_stall;
  logic [31:0] rs_data, rt_data;
  int checks = 0, failures = 0;
  logic [63:0] sb[$];

  regfile_read_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_valid(rd_valid), .rs_data(rs_data), .rt_data(rt_data), .rd_stall(rd_stall),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      logic [63:0] e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: rd_valid with rs=%h rt=%h, none expected", rs_data, rt_data);
      end else begin
        e = sb.pop_front();
        if ({rs_data, rt_data} !== e) begin
          failures++;
          $display("FAIL sb_data: got rs=%h rt=%h, want rs=%h rt=%h", rs_data, rt_data, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    #2;
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", rd_valid); end
    if (rd_stall !== 1'b0) begin failures++; $display("FAIL rst_stall: got %b want 0", rd_stall); end
    if (rs_data !== 32'h0) begin failures++; $display("FAIL rst_rs: got %h want 0", rs_data); end
    if (rt_data !== 32'h0) begin failures++; $display("FAIL rst_rt: got %h want 0", rt_data); end
    checks += 4;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic_read();
    wr_en = 1; wr_addr = 5; wr_data = 32'hA5;
    tick();
    wr_en = 0; rd_req = 1; rs_addr = 5; rt_addr = 0;
    sb.push_back({32'hA5, 32'h0});
    tick();
    rd_req = 0;
    chk("basic_valid", {31'b0, rd_valid}, 1);
    chk("basic_stall", {31'b0, rd_stall}, 0);
    tick();
    chk("basic_pulse", {31'b0, rd_valid}, 0);
  endtask

  task automatic test_stall_bypass();
    rsv_en = 1; rsv_addr = 7;
    tick();
    rsv_en = 0; rd_req = 1; rs_addr = 7; rt_addr = 5;
    tick();
    chk("wait_stall", {31'b0, rd_stall}, 1);
    chk("wait_valid", {31'b0, rd_valid}, 0);
    rs_addr = 5; rt_addr = 5;  // must be ignored while waiting
    tick();
    chk("wait_hold1", {31'b0, rd_stall}, 1);
    tick();
    chk("wait_hold2", {31'b0, rd_stall}, 1);
    rd_req = 0; wr_en = 1; wr_addr = 7; wr_data = 32'h1234;
    sb.push_back({32'h1234, 32'hA5});
    tick();
    wr_en = 0;
    chk("bypass_valid", {31'b0, rd_valid}, 1);
    chk("bypass_stall", {31'b0, rd_stall}, 0);
    rd_req = 1; rs_addr = 7; rt_addr = 7;
    sb.push_back({32'h1234, 32'h1234});
    tick();
    rd_req = 0;
    chk("cleared_valid", {31'b0, rd_valid}, 1);
    tick();
  endtask

  task automatic test_reserve_wins();
    rsv_en = 1; rsv_addr = 9; wr_en = 1; wr_addr = 9; wr_data = 32'h55;
    tick();
    rsv_en = 0; wr_en = 0; rd_req = 1; rs_addr = 9; rt_addr = 0;
    tick();
    rd_req = 0;
    chk("rsvwin_stall", {31'b0, rd_stall}, 1);
    tick();
    chk("rsvwin_hold", {31'b0, rd_stall}, 1);
    wr_en = 1; wr_addr = 9; wr_data = 32'h66;
    sb.push_back({32'h66, 32'h0});
    tick();
    wr_en = 0;
    chk("rsvwin_valid", {31'b0, rd_valid}, 1);
    tick();
  endtask

  task automatic test_same_addr_bypass();
    rsv_en = 1; rsv_addr = 3;
    tick();
    rsv_en = 0; rd_req = 1; rs_addr = 3; rt_addr = 3; wr_en = 1; wr_addr = 3; wr_data = 32'hDEAD;
    sb.push_back({32'hDEAD, 32'hDEAD});
    tick();
    rd_req = 0; wr_en = 0;
    chk("same_valid", {31'b0, rd_valid}, 1);
    chk("same_stall", {31'b0, rd_stall}, 0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ra [3] = '{5, 7, 3};
    logic [4:0]  rb [3] = '{3, 9, 5};
    logic [63:0] ex [3] = '{{32'hA5, 32'hDEAD}, {32'h1234, 32'h66}, {32'hDEAD, 32'hA5}};
    for (int i = 0; i < 3; i++) begin
      rd_req = 1; rs_addr = ra[i]; rt_addr = rb[i];
      sb.push_back(ex[i]);
      tick();
      chk("b2b_valid", {31'b0, rd_valid}, 1);
    end
    rd_req = 0;
    tick();
    chk("b2b_end", {31'b0, rd_valid}, 0);
  endtask

  task automatic test_reset_in_wait();
    rsv_en = 1; rsv_addr = 11;
    tick();
    rsv_en = 0; rd_req = 1; rs_addr = 11; rt_addr = 5;
    tick();
    rd_req = 0;
    chk("rstw_stall_before", {31'b0, rd_stall}, 1);
    #2 rst_n = 0;
    #1;
    chk("rstw_stall", {31'b0, rd_stall}, 0);
    chk("rstw_valid", {31'b0, rd_valid}, 0);
    tick();
    #2 rst_n = 1;
    tick();
    chk("rstw_no_valid", {31'b0, rd_valid}, 0);
    tick();
    chk("rstw_no_stall", {31'b0, rd_stall}, 0);
    rd_req = 1; rs_addr = 11; rt_addr = 5;
    sb.push_back({32'h0, 32'h0});
    tick();
    rd_req = 0;
    chk("rstw_clear_valid", {31'b0, rd_valid}, 1);
    tick();
  endtask

  task automatic test_reg0();
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFF_FFFF; rsv_en = 1; rsv_addr = 0;
    tick();
    wr_en = 0; rsv_en = 0; rd_req = 1; rs_addr = 0; rt_addr = 0;
`ifdef REG0_HARDWIRED_EN
    sb.push_back({32'h0, 32'h0});
    tick();
    rd_req = 0;
    chk("reg0_valid", {31'b0, rd_valid}, 1);
    chk("reg0_stall", {31'b0, rd_stall}, 0);
`else
    tick();
    rd_req = 0;
    chk("reg0_stall", {31'b0, rd_stall}, 1);
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFF_FFFF;
    sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFF});
    tick();
    wr_en = 0;
    chk("reg0_valid", {31'b0, rd_valid}, 1);
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_stall_bypass();
    test_reserve_wins();
    test_same_addr_bypass();
    test_back_to_back();
    test_reset_in_wait();
    test_reg0();
    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
